// File: rtl/dmr_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
package dmr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dmr_state_e;

    localparam int WORD_BYTES = 4;

    // Number of beats needed to move one word when bpb bytes go per beat.
    function automatic int beatCount(input int bpb);
        return WORD_BYTES / bpb;
    endfunction

endpackage

// File: rtl/mem_byte_bank.sv
// Byte-wide storage array with a BPB-byte big-endian window.
// The byte at addr lands in the most significant lane of the window, and
// addresses past the top of the array wrap back to zero.
module mem_byte_bank #(
    parameter int DEPTH = 256,
    parameter int BPB   = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 wrEn,
    input  logic [AW-1:0]        addr,
    input  logic [8*BPB-1:0]     wrData,
    output logic [8*BPB-1:0]     rdData
);

    logic [7:0] mem [DEPTH];

    // Combinational read of BPB consecutive bytes, first byte in the top lane.
    always_comb begin
        rdData = '0;
        for (int i = 0; i < BPB; i++) begin
            rdData[8*(BPB-1-i) +: 8] = mem[addr + AW'(i)];
        end
    end

    // Byte writes for the current beat; reset wipes the whole array.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= 8'h00;
            end
        end else if (wrEn) begin
            for (int i = 0; i < BPB; i++) begin
                mem[addr + AW'(i)] <= wrData[8*(BPB-1-i) +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: serves word loads and stores from a byte
// array a few bytes per cycle and stalls the pipeline with memHAZ meanwhile.
// The first beat is moved on the same edge that accepts the request, so the
// stall lasts exactly NB cycles (request cycle included) before DONE.
module data_mem_responder
    import dmr_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int BPB   = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        memHAZ,
    output logic        alignErr
);

    localparam int AW        = $clog2(DEPTH);
    localparam int NB        = beatCount(BPB);
    localparam int BEAT_BITS = 8 * BPB;

    dmr_state_e              state;
    logic [1:0]              beat;
    logic [AW-1:0]           latchedAddr;
    logic [31:0]             latchedData;
    logic [31:0]             asmReg;

    logic                    inIdle;
    logic                    request;
    logic                    aligned;
    logic                    acceptWr;
    logic                    acceptRd;
    logic                    bankWrEn;
    logic [1:0]              beatEff;
    logic [AW-1:0]           baseAddr;
    logic [AW-1:0]           bankAddr;
    logic [31:0]             wordSrc;
    logic [31:0]             wordShift;
    logic [BEAT_BITS-1:0]    bankWrData;
    logic [BEAT_BITS-1:0]    bankRdData;
    logic [31:0]             assembled;
    logic                    lastBeat;

    // Beat addressing and data steering; in IDLE the live bus drives beat 0.
    always_comb begin
        inIdle     = (state == IDLE);
        request    = memRead | memWrite;
        aligned    = (Address[1:0] == 2'b00);
        acceptWr   = inIdle & memWrite & aligned;
        acceptRd   = inIdle & ~memWrite & memRead & aligned;
        bankWrEn   = acceptWr | (state == WR);
        beatEff    = inIdle ? 2'd0 : beat;
        baseAddr   = inIdle ? Address[AW-1:0] : latchedAddr;
        bankAddr   = baseAddr + AW'(beatEff) * AW'(BPB);
        wordSrc    = inIdle ? WriteData : latchedData;
        wordShift  = wordSrc << (BEAT_BITS * int'(beatEff));
        bankWrData = wordShift[31 -: BEAT_BITS];
        assembled  = (inIdle ? 32'd0 : (asmReg << BEAT_BITS)) | 32'(bankRdData);
        lastBeat   = (int'(beatEff) == NB - 1);
    end

    // Stall while an access is in flight or an aligned request is being accepted.
    always_comb begin
        memHAZ = Rst & ((state == RD) | (state == WR) | (inIdle & request & aligned));
    end

    // Request acceptance, beat sequencing and load-word capture.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            beat        <= 2'd0;
            latchedAddr <= '0;
            latchedData <= 32'd0;
            asmReg      <= 32'd0;
            ReadData    <= 32'd0;
            alignErr    <= 1'b0;
        end else begin
            alignErr <= inIdle & request & ~aligned;
            case (state)
                IDLE: begin
                    if (acceptWr | acceptRd) begin
                        latchedAddr <= Address[AW-1:0];
                        if (acceptWr) begin
                            latchedData <= WriteData;
                        end else begin
                            asmReg <= assembled;
                        end
                        beat <= 2'd1;
                        if (lastBeat) begin
                            state <= DONE;
                            if (acceptRd) begin
                                ReadData <= assembled;
                            end
                        end else begin
                            state <= acceptWr ? WR : RD;
                        end
                    end
                end
                RD, WR: begin
                    if (state == RD) begin
                        asmReg <= assembled;
                    end
                    beat <= beat + 2'd1;
                    if (lastBeat) begin
                        state <= DONE;
                        if (state == RD) begin
                            ReadData <= assembled;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    beat  <= 2'd0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_byte_bank #(
        .DEPTH (DEPTH),
        .BPB   (BPB),
        .AW    (AW)
    ) bank (
        .Clk    (Clk),
        .Rst    (Rst),
        .wrEn   (bankWrEn),
        .addr   (bankAddr),
        .wrData (bankWrData),
        .rdData (bankRdData)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array reference model
// predicts ReadData for every accepted access, and a monitor compares it
// whenever the DUT drops memHAZ into its DONE cycle.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int BPB   = 1;
    localparam int NB    = 4 / BPB;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        memHAZ;
    logic        alignErr;

    int          checkCount = 0;
    int          passCount = 0;

    logic [7:0]  model [DEPTH];
    logic [31:0] lastRead = 32'd0;
    logic [31:0] expQ [$];
    string       nameQ [$];
    logic        prevHaz = 1'b0;

    data_mem_responder #(
        .DEPTH (DEPTH),
        .BPB   (BPB)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .memHAZ    (memHAZ),
        .alignErr  (alignErr)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            w = {w[23:0], model[(addr + 32'(k)) & (DEPTH - 1)]};
        end
        return w;
    endfunction

    task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data);
        for (int k = 0; k < 4; k++) begin
            model[(addr + 32'(k)) & (DEPTH - 1)] = data[31 - 8*k -: 8];
        end
    endtask

    task automatic modelClear();
        for (int k = 0; k < DEPTH; k++) begin
            model[k] = 8'h00;
        end
        lastRead = 32'd0;
    endtask

    // Monitor: the falling edge of memHAZ marks DONE, where ReadData is compared.
    always @(negedge Clk) begin
        #2;
        if (!Rst) begin
            prevHaz = 1'b0;
        end else begin
            if (prevHaz && !memHAZ) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected completion: got %08h expected none", ReadData);
                end else begin
                    checkOutput(nameQ.pop_front(), ReadData, expQ.pop_front());
                end
            end
            prevHaz = memHAZ;
        end
    end

    // Drive one request like the pipeline would: hold it while stalled, keep
    // it through DONE, then drop it. Optionally change Address mid-access.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic changeAddr,
                                 input logic [31:0] newAddr);
        int cnt;
        @(negedge Clk);
        memRead   = rd;
        memWrite  = wr;
        Address   = addr;
        WriteData = data;
        #1;
        if (addr[1:0] == 2'b00) begin
            if (wr) begin
                modelWrite(addr, data);
                expQ.push_back(lastRead);
                nameQ.push_back("ReadData after store");
            end else begin
                lastRead = modelRead(addr);
                expQ.push_back(lastRead);
                nameQ.push_back("load data");
            end
            cnt = 0;
            while (memHAZ === 1'b1 && cnt < 20) begin
                cnt++;
                @(negedge Clk);
                if (changeAddr && cnt == 1) Address = newAddr;
                #1;
            end
            checkOutput("stall length", 32'(cnt), 32'(NB));
            @(negedge Clk);
            memRead  = 1'b0;
            memWrite = 1'b0;
            #1;
        end else begin
            checkOutput("misaligned memHAZ", 32'(memHAZ), 32'd0);
            @(negedge Clk);
            memRead  = 1'b0;
            memWrite = 1'b0;
            #1;
            checkOutput("alignErr pulse", 32'(alignErr), 32'd1);
            @(negedge Clk);
            #1;
            checkOutput("alignErr clears", 32'(alignErr), 32'd0);
            checkOutput("ReadData after misaligned", ReadData, lastRead);
        end
    endtask

    // Hard stop if something hangs.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed cases, random traffic, reset mid-read.
    initial begin
        logic [31:0] addr;
        logic [31:0] data;
        int          op;

        modelClear();
        Rst      = 1'b0;
        memRead  = 1'b1;
        Address  = 32'h10;
        repeat (2) @(negedge Clk);
        #1;
        checkOutput("memHAZ in reset", 32'(memHAZ), 32'd0);
        checkOutput("ReadData in reset", ReadData, 32'd0);
        memRead = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        #1;
        checkOutput("ReadData idle", ReadData, 32'd0);
        checkOutput("memHAZ idle", 32'(memHAZ), 32'd0);
        checkOutput("alignErr idle", 32'(alignErr), 32'd0);

        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        checkOutput("byte mem[0x10]", 32'(dut.bank.mem[16]), 32'h000000DE);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0);

        applyStimulus(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b1, 32'h40);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);

        applyStimulus(1'b0, 1'b1, 32'h1FC, 32'hA1B2C3D4, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            op   = int'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            data = $urandom;
            applyStimulus(op != 1, op != 0, addr, data, 1'b0, 32'h0);
        end

        applyStimulus(1'b0, 1'b1, 32'h50, 32'hCAFEF00D, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0);
        @(negedge Clk);
        memRead = 1'b1;
        Address = 32'h50;
        repeat (2) @(negedge Clk);
        #1;
        checkOutput("memHAZ during beat 2", 32'(memHAZ), 32'd1);
        Rst = 1'b0;
        #1;
        checkOutput("memHAZ on async reset", 32'(memHAZ), 32'd0);
        checkOutput("ReadData on async reset", ReadData, 32'd0);
        expQ.delete();
        nameQ.delete();
        modelClear();
        memRead = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0);

        repeat (3) @(negedge Clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
